// File: rtl/fifo_tg_pkg.sv
// Shared definitions for the FIFO traffic generator: default widths and the
// controller state encoding.
package fifo_tg_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_LEN_W  = 8;
    localparam int DEF_GAP_W  = 8;
    localparam int DEF_ERR_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_GAP   = 3'd2,
        ST_READ  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/fifo_tg_checker.sv
// Read-back checker: tracks the expected word, compares each returned FIFO
// word one cycle after its read strobe, and keeps a saturating mismatch count
// plus the expected value of the first mismatch of the run.
module fifo_tg_checker
    import fifo_tg_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ERR_W  = DEF_ERR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic [DATA_W-1:0] load_value,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ERR_W-1:0]  err_count,
    output logic [DATA_W-1:0] first_err
);

    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    logic              rd_v_q, rd_v_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [DATA_W-1:0] first_q, first_d;

    assign err_count = err_q;
    assign first_err = first_q;

    // Next-state: compare on rd_v, then apply pass load and run clear on top.
    always_comb begin
        rd_v_d  = rd_en;
        exp_d   = exp_q;
        err_d   = err_q;
        first_d = first_q;
        if (rd_v_q) begin
            exp_d = exp_q + 1'b1;
            if (rd_data != exp_q) begin
                if (err_q != ERR_MAX) err_d = err_q + 1'b1;
                if (err_q == '0) first_d = exp_q;
            end
        end
        if (load) exp_d = load_value;
        if (clr) begin
            err_d   = '0;
            first_d = '0;
        end
    end

    // Checker registers; reset clears everything including the data path.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_v_q  <= 1'b0;
            exp_q   <= '0;
            err_q   <= '0;
            first_q <= '0;
        end else begin
            rd_v_q  <= rd_v_d;
            exp_q   <= exp_d;
            err_q   <= err_d;
            first_q <= first_d;
        end
    end

endmodule

// File: rtl/fifo_traffic_gen.sv
// FIFO exerciser: writes a burst of incrementing words, idles for a gap,
// reads the burst back and hands every returned word to the checker.
// Looped runs continue the pattern across passes until stop is seen in DONE.
module fifo_traffic_gen
    import fifo_tg_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int GAP_W  = DEF_GAP_W,
    parameter int ERR_W  = DEF_ERR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              loop_mode,
    input  logic              stop,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic [GAP_W-1:0]  gap_cycles,
    input  logic [DATA_W-1:0] seed,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_wr_data,
    input  logic              fifo_full,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              fifo_empty,
    output logic              busy,
    output logic              pass_done,
    output logic [ERR_W-1:0]  err_count,
    output logic [DATA_W-1:0] first_err
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] wr_word_q, wr_word_d;
    logic [LEN_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [LEN_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              loop_q, loop_d;
    logic              start_go, next_pass, chk_load;
    logic [DATA_W-1:0] chk_load_value;

    // Strobes are gated by the FIFO flags combinationally so a full or empty
    // FIFO is never written or read, even on the cycle the flag rises.
    assign fifo_wr_en     = (state_q == ST_WRITE) && !fifo_full;
    assign fifo_rd_en     = (state_q == ST_READ) && !fifo_empty;
    assign fifo_wr_data   = wr_word_q;
    assign busy           = (state_q != ST_IDLE);
    assign pass_done      = (state_q == ST_DONE);
    assign start_go       = (state_q == ST_IDLE) && start;
    assign next_pass      = (state_q == ST_DONE) && loop_q && !stop;
    // The checker's expected word restarts at seed on a new run and at the
    // current write word for each following pass of a looped run.
    assign chk_load       = start_go || next_pass;
    assign chk_load_value = start_go ? seed : wr_word_q;

    // Controller next-state and counter updates.
    always_comb begin
        state_d   = state_q;
        wr_word_d = wr_word_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        len_d     = len_q;
        gap_cnt_d = gap_cnt_q;
        gap_d     = gap_q;
        loop_d    = loop_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_WRITE;
                    wr_word_d = seed;
                    wr_cnt_d  = '0;
                    rd_cnt_d  = '0;
                    gap_cnt_d = '0;
                    len_d     = (burst_len == '0) ? LEN_W'(1) : burst_len;
                    gap_d     = gap_cycles;
                    loop_d    = loop_mode;
                end
            end
            ST_WRITE: begin
                if (fifo_wr_en) begin
                    wr_word_d = wr_word_q + 1'b1;
                    if (wr_cnt_q == len_q - 1'b1) begin
                        wr_cnt_d  = '0;
                        gap_cnt_d = '0;
                        state_d   = (gap_q == '0) ? ST_READ : ST_GAP;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == gap_q - 1'b1) begin
                    gap_cnt_d = '0;
                    state_d   = ST_READ;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            ST_READ: begin
                if (fifo_rd_en) begin
                    if (rd_cnt_q == len_q - 1'b1) begin
                        rd_cnt_d = '0;
                        state_d  = ST_DRAIN;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                end
            end
            // The last read's data is compared by the checker during DRAIN.
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = (loop_q && !stop) ? ST_WRITE : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Controller registers; reset aborts any pass immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            wr_word_q <= '0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            len_q     <= '0;
            gap_cnt_q <= '0;
            gap_q     <= '0;
            loop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_word_q <= wr_word_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            len_q     <= len_d;
            gap_cnt_q <= gap_cnt_d;
            gap_q     <= gap_d;
            loop_q    <= loop_d;
        end
    end

    fifo_tg_checker #(
        .DATA_W (DATA_W),
        .ERR_W  (ERR_W)
    ) u_checker (
        .clk        (clk),
        .rst        (rst),
        .clr        (start_go),
        .load       (chk_load),
        .load_value (chk_load_value),
        .rd_en      (fifo_rd_en),
        .rd_data    (fifo_rd_data),
        .err_count  (err_count),
        .first_err  (first_err)
    );

endmodule

// File: tb/tb_fifo_traffic_gen.sv
// Bench for fifo_traffic_gen: a queue-based FIFO model with optional word
// corruption, a per-cycle compare process and directed plus random runs.
module tb_fifo_traffic_gen;

    localparam int DW = 8, LW = 8, GW = 8, EW = 16, DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst, start, loop_mode, stop;
    logic [LW-1:0] burst_len;
    logic [GW-1:0] gap_cycles;
    logic [DW-1:0] seed;
    logic          fifo_wr_en, fifo_rd_en, fifo_full, fifo_empty;
    logic [DW-1:0] fifo_wr_data, fifo_rd_data;
    logic          busy, pass_done;
    logic [EW-1:0] err_count;
    logic [DW-1:0] first_err;

    always #5 clk = ~clk;

    fifo_traffic_gen #(.DATA_W(DW), .LEN_W(LW), .GAP_W(GW), .ERR_W(EW)) dut (
        .clk(clk), .rst(rst), .start(start), .loop_mode(loop_mode), .stop(stop),
        .burst_len(burst_len), .gap_cycles(gap_cycles), .seed(seed),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_full(fifo_full),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
        .busy(busy), .pass_done(pass_done), .err_count(err_count), .first_err(first_err)
    );

    int n_vec = 0, n_bad = 0;

    function automatic void chk_eq(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endfunction

    // ---------------- FIFO model with corruption ----------------
    logic [DW-1:0] q[$];
    int            occ = 0;
    logic          force_full = 1'b0, force_empty = 1'b0;
    int            cmode = 0, ca = -1, cb = -1;
    int            rd_idx = 0, merr = 0;
    logic [DW-1:0] mfirst = '0;
    logic [DW-1:0] v, vo;
    // strobes captured at the falling edge, acted on at the next rising edge
    logic          wr_s = 1'b0, rd_s = 1'b0, go_s = 1'b0;
    logic [DW-1:0] wd_s = '0;
    int            cyc = 0;

    assign fifo_full  = force_full || (occ >= DEPTH);
    assign fifo_empty = force_empty || (occ == 0);

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            fifo_rd_data <= '0;
        end else begin
            if (go_s) begin
                rd_idx = 0;
                merr   = 0;
                mfirst = '0;
            end
            if (rd_s) begin
                chk_eq("fifo_underflow", (q.size() == 0), 0);
                if (q.size() != 0) begin
                    v  = q.pop_front();
                    vo = v;
                    if (cmode == 1 && (rd_idx == ca || rd_idx == cb)) vo = '0;
                    if (cmode == 2 && ($urandom % 8) == 0) vo = v ^ DW'($urandom_range(1, 255));
                    if (vo != v) begin
                        merr++;
                        if (merr == 1) mfirst = v;
                    end
                    fifo_rd_data <= vo;
                    rd_idx++;
                end
            end
            if (wr_s) begin
                chk_eq("fifo_overflow", (q.size() >= DEPTH), 0);
                if (q.size() < DEPTH) q.push_back(wd_s);
            end
        end
        occ <= q.size();
    end

    // ---------------- per-cycle compare against run model ----------------
    logic [DW-1:0] exp_wr = '0;
    logic [DW-1:0] wlog[0:63];
    int  nwr = 0, nrd = 0, npd = 0, pwr = 0, prd = 0, leff = 1, gap_l = 0;
    int  start_cyc = 0, last_wr_cyc = 0;
    bit  loop_l = 0, ideal = 0, prev_pd = 0, prev_end = 0;

    always @(negedge clk) begin
        wr_s = fifo_wr_en;
        rd_s = fifo_rd_en;
        wd_s = fifo_wr_data;
        go_s = start && !busy && !rst;
        if (!rst) begin
            if (prev_end)     chk_eq("busy_after_last_done", busy, 0);
            else if (prev_pd) chk_eq("busy_between_passes", busy, 1);
        end
        if (go_s) begin
            exp_wr    = seed;
            nwr = 0; nrd = 0; npd = 0; pwr = 0; prd = 0;
            leff      = (burst_len == 0) ? 1 : int'(burst_len);
            gap_l     = int'(gap_cycles);
            loop_l    = loop_mode;
            start_cyc = cyc;
            ideal     = 1;
        end
        if (force_full || force_empty) ideal = 0;
        if (!busy) chk_eq("idle_strobes", {wr_s, rd_s, pass_done}, 0);
        if (wr_s) begin
            chk_eq("wr_while_full", fifo_full, 0);
            chk_eq("wr_data", wd_s, exp_wr);
            chk_eq("wr_past_burst", (pwr >= leff), 0);
            if (nwr == 0 && ideal) chk_eq("first_wr_latency", cyc, start_cyc + 1);
            if (nwr < 64) wlog[nwr] = wd_s;
            exp_wr = exp_wr + 1'b1;
            nwr++;
            pwr++;
            if (pwr == leff) last_wr_cyc = cyc;
        end
        if (rd_s) begin
            chk_eq("rd_while_empty", fifo_empty, 0);
            chk_eq("rd_before_burst_written", pwr, leff);
            if (prd == 0 && ideal) chk_eq("first_rd_timing", cyc, last_wr_cyc + 1 + gap_l);
            prd++;
            nrd++;
            chk_eq("rd_past_burst", (prd > leff), 0);
        end
        if (pass_done && !rst) begin
            chk_eq("pass_counts", {pwr[15:0], prd[15:0]}, {leff[15:0], leff[15:0]});
            npd++;
            pwr = 0;
            prd = 0;
        end
        prev_pd  = pass_done && !rst;
        prev_end = pass_done && !rst && (!loop_l || stop);
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // stall: 0 none, 1 random flags + stray starts, 2 fixed full/empty windows
    task automatic do_run(input logic [DW-1:0] s, input int len, input int gap, input bit lp,
                          input int stop_after, input int cm, input int a, input int b,
                          input int stall);
        int le, exp_p, arm, e_left, t;
        bit done_e;
        le     = (len == 0) ? 1 : len;
        exp_p  = lp ? stop_after : 1;
        seed = s; burst_len = LW'(len); gap_cycles = GW'(gap); loop_mode = lp;
        cmode = cm; ca = a; cb = b;
        stop   = lp ? 1'b0 : 1'($urandom % 2);
        start  = 1'b1;
        tick(1);
        start  = 1'b0;
        // inputs are latched on start; scramble them to prove it
        seed = DW'($urandom); burst_len = LW'($urandom); gap_cycles = GW'($urandom);
        loop_mode = 1'($urandom);
        arm = -1; e_left = 0; done_e = 0;
        for (t = 0; t < 4000 && busy; t++) begin
            start = 1'b0;
            if (lp && !stop) begin
                if (arm < 0 && npd >= stop_after - 1) arm = 2;
                else if (arm > 0) begin
                    arm--;
                    if (arm == 0) stop = 1'b1;
                end
            end
            if (stall == 1) begin
                force_full  = ($urandom % 4) == 0;
                force_empty = ($urandom % 4) == 0;
                if (($urandom % 16) == 0) start = 1'b1;
            end else if (stall == 2) begin
                force_full = (t >= 1 && t < 6);
                if (!done_e && nrd >= 1) begin
                    e_left = 3;
                    done_e = 1;
                end
                force_empty = (e_left > 0);
                if (e_left > 0) e_left--;
            end
            tick(1);
        end
        start = 1'b0; force_full = 1'b0; force_empty = 1'b0;
        chk_eq("run_timeout_busy", busy, 0);
        chk_eq("passes", npd, exp_p);
        chk_eq("writes", nwr, exp_p * le);
        chk_eq("reads", nrd, exp_p * le);
        chk_eq("err_count", err_count, EW'(merr));
        chk_eq("first_err", first_err, mfirst);
        chk_eq("fifo_left", occ, 0);
        stop = 1'b0;
        tick(1);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; loop_mode = 1'b0; stop = 1'b0;
        burst_len = '0; gap_cycles = '0; seed = '0;
        tick(3);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_wr_en", fifo_wr_en, 0);
        chk_eq("rst_rd_en", fifo_rd_en, 0);
        chk_eq("rst_wr_data", fifo_wr_data, 0);
        chk_eq("rst_pass_done", pass_done, 0);
        chk_eq("rst_err_count", err_count, 0);
        chk_eq("rst_first_err", first_err, 0);
        // start together with reset: reset wins
        seed = 8'h77; burst_len = 8'd2; start = 1'b1;
        tick(1);
        start = 1'b0;
        chk_eq("rst_beats_start", busy, 0);
        rst = 1'b0;
        tick(1);

        // single pass, gap 0
        do_run(8'hAA, 4, 0, 0, 1, 0, -1, -1, 0);
        chk_eq("sp_w0", wlog[0], 8'hAA);
        chk_eq("sp_w1", wlog[1], 8'hAB);
        chk_eq("sp_w2", wlog[2], 8'hAC);
        chk_eq("sp_w3", wlog[3], 8'hAD);
        chk_eq("sp_err", err_count, 0);

        // pattern wrap
        do_run(8'hFE, 3, 2, 0, 1, 0, -1, -1, 0);
        chk_eq("wrap_w1", wlog[1], 8'hFF);
        chk_eq("wrap_w2", wlog[2], 8'h00);

        // backpressure windows
        do_run(8'h40, 6, 2, 0, 1, 0, -1, -1, 2);
        chk_eq("bp_err", err_count, 0);

        // error injection: second word corrupted, then second and fourth
        do_run(8'hAA, 4, 0, 0, 1, 1, 1, -1, 0);
        chk_eq("inj1_err", err_count, 1);
        chk_eq("inj1_first", first_err, 8'hAB);
        chk_eq("inj1_model", merr, 1);
        do_run(8'hAA, 4, 1, 0, 1, 1, 1, 3, 0);
        chk_eq("inj2_err", err_count, 2);
        chk_eq("inj2_first", first_err, 8'hAB);

        // loop mode stopped during pass 2
        do_run(8'h10, 2, 1, 1, 2, 0, -1, -1, 0);
        chk_eq("loop_passes", npd, 2);
        chk_eq("loop_w2", wlog[2], 8'h12);
        chk_eq("loop_w3", wlog[3], 8'h13);

        // reset mid-burst after two writes
        seed = 8'h33; burst_len = 8'd8; gap_cycles = '0; loop_mode = 1'b0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(1);
        chk_eq("mid_rst_busy", busy, 0);
        chk_eq("mid_rst_strobes", {fifo_wr_en, fifo_rd_en, pass_done}, 0);
        chk_eq("mid_rst_wr_data", fifo_wr_data, 0);
        chk_eq("mid_rst_err", err_count, 0);
        rst = 1'b0;
        tick(3);
        chk_eq("mid_rst_writes", nwr, 2);
        do_run(8'h5A, 3, 0, 0, 1, 0, -1, -1, 0);
        chk_eq("restart_w0", wlog[0], 8'h5A);
        chk_eq("restart_w2", wlog[2], 8'h5C);

        // randomized runs
        for (int r = 0; r < 30; r++) begin
            do_run(DW'($urandom), $urandom_range(0, 16), $urandom_range(0, 6),
                   1'(($urandom % 3) == 0), $urandom_range(1, 3),
                   (($urandom % 2) == 0) ? 2 : 0, -1, -1, $urandom_range(0, 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_traffic_gen.md
Name: fifo_traffic_gen

Overview:
Parametrised FIFO exerciser and successor to the single-word write/read test sequencer. Writes a burst of incrementing words into a FIFO, waits a programmable gap, then reads the burst back. Checks every returned word against the expected sequence and counts mismatches. Supports single-pass and looped operation. Sits between a FIFO under test and status/debug logic.

Parameters:
DATA_W, 8, FIFO data width; the pattern wraps modulo 2^DATA_W.
LEN_W, 8, width of burst_len and of the internal word counters.
GAP_W, 8, width of gap_cycles and of the gap counter.
ERR_W, 16, width of err_count; the count saturates.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  1-cycle pulse; begins a run when in IDLE, ignored otherwise
loop_mode  in  1  1 = repeat passes until stop; 0 = single pass; latched on start
stop  in  1  level; ends a looped run at the next pass boundary
burst_len  in  LEN_W  words per pass; 0 is treated as 1; latched on start
gap_cycles  in  GAP_W  idle cycles between last write and first read; latched on start
seed  in  DATA_W  first pattern word; latched on start
fifo_wr_en  out  1  FIFO write strobe
fifo_wr_data  out  DATA_W  FIFO write data
fifo_full  in  1  FIFO full
fifo_rd_en  out  1  FIFO read strobe
fifo_rd_data  in  DATA_W  FIFO read data, valid 1 cycle after fifo_rd_en
fifo_empty  in  1  FIFO empty
busy  out  1  high in any state other than IDLE
pass_done  out  1  1-cycle pulse at the end of each pass
err_count  out  ERR_W  total mismatches since start, saturating
first_err  out  DATA_W  expected value at the first mismatch of the run

Behaviour:
- Reset (clk edge with rst=1): state IDLE; all outputs 0; all counters 0. Reset mid-pass aborts immediately with no further FIFO strobes.
- States: IDLE, WRITE, GAP, READ, DRAIN, DONE.
- IDLE -> WRITE on start. Start clears err_count and first_err, and loads wr_word = seed.
- WRITE:
  - fifo_wr_en = (state==WRITE) && !fifo_full; this is combinational so the block never writes when full.
  - fifo_wr_data = wr_word (registered).
  - Each accepted write increments wr_word modulo 2^DATA_W and increments wr_cnt.
  - A full FIFO stalls the burst without dropping or duplicating words.
  - After the write with wr_cnt == len-1: go to GAP, or to READ if gap_cycles == 0.
- GAP: count gap_cycles cycles with no strobes, then go to READ.
- READ:
  - fifo_rd_en = (state==READ) && !fifo_empty; combinational.
  - Each issued read increments rd_cnt.
  - After the read with rd_cnt == len-1: go to DRAIN.
- Checking:
  - A register rd_v is set the cycle after any fifo_rd_en.
  - When rd_v=1, compare fifo_rd_data with exp_word, then increment exp_word modulo 2^DATA_W.
  - exp_word is loaded from the pass's first word at the start of each pass.
  - On mismatch: err_count += 1, saturating at 2^ERR_W-1. first_err is captured only when err_count was 0.
- DRAIN: one cycle; the final word is compared here; then go to DONE.
- DONE: pass_done = 1 for one cycle. Next state is WRITE if loop_mode && !stop, else IDLE.
  - The next pass continues the pattern from the current wr_word value, not from seed.
  - err_count holds its value in IDLE until the next start.
- Simultaneous start and rst: rst wins.
- stop asserted mid-pass does not truncate the pass; it is sampled only in DONE.
- Latency: the first fifo_wr_en is asserted the cycle after start, provided the FIFO is not full.

Decomposition:
- Package fifo_tg_pkg holds the state encoding constants (IDLE..DONE) and the default widths.
- Natural sub-module: fifo_tg_checker. It contains the rd_v register, exp_word, the comparator, the saturating err_count and first_err capture. It takes load/load_value/rd_en/rd_data as inputs.
- The FSM and write side stay in the top module.

Test Plan:
- Single pass, seed=0xAA, len=4, gap=0, ideal FIFO model -> writes AA,AB,AC,AD; reads issued from the cycle after the last write; pass_done pulses once; err_count=0; busy falls the cycle after DONE.
- Wrap: seed=0xFE, len=3 -> writes FE,FF,00; the check passes with no error.
- Backpressure: hold fifo_full=1 for 5 cycles during the write burst and fifo_empty=1 for 3 cycles during the read -> no strobes while the flag is high; the sequence is unbroken; err_count=0.
- Error injection: the FIFO model corrupts the 2nd read word (0xAB -> 0x00), seed=0xAA -> err_count=1, first_err=0xAB; a 2nd corruption gives err_count=2 with first_err unchanged.
- Loop mode: len=2, seed=0x10, stop raised during pass 2 -> exactly 2 pass_done pulses; pass 2 writes 12,13; returns to IDLE.
- Reset mid-burst: rst asserted after 2 of 8 writes -> the next cycle has all outputs 0 and the state is IDLE; a new start restarts cleanly from the new seed.
